apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
- N-channel APB4 master-side multiplexer/arbiter. Generalises the static two-way single-clock/multi-clock pin mux.
- Each of NCH upstream APB4 requesters presents a complete request. The block grants one, re-issues it downstream as a registered SETUP/ACCESS pair, and returns the response to the owner only.
- Switching between channels happens only at transfer boundaries, never mid-transfer.
- Sits between the bridge cores (single-clock, multi-clock, test) and the external APB4 bus.

Parameters:
- NCH, 2, number of upstream channels; legal range 2..16.
- AW, 32, address width.
- DW, 32, data width; legal values 8/16/32.
- TIMEOUT, 0, ACCESS-phase watchdog limit in cycles (max 65535); 0 disables the watchdog.
- SELW (localparam), $clog2(NCH), channel index width.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- s_psel  in  NCH  per-channel select
- s_paddr  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW]
- s_pwrite  in  NCH  per-channel write
- s_pprot  in  NCH*3  per-channel protection
- s_pwdata  in  NCH*DW  per-channel write data
- s_pstrb  in  NCH*DW/8  per-channel strobes
- s_pready  out  NCH  per-channel ready
- s_prdata  out  NCH*DW  per-channel read data
- s_pslverr  out  NCH  per-channel error
- PSELx  out  1  downstream select
- PADDR  out  AW  downstream address
- PENABLE  out  1  downstream enable
- PWRITE  out  1  downstream write
- PPROT  out  3  downstream protection
- PWDATA  out  DW  downstream write data
- PSTRB  out  DW/8  downstream strobes
- PREADY  in  1  downstream ready
- PRDATA  in  DW  downstream read data
- PSLVERR  in  1  downstream error
- arb_mode  in  1  0 = fixed select via sel_req; 1 = round-robin
- sel_req  in  SELW  fixed-mode channel index
- cur_owner  out  SELW  channel of the current or last transfer
- busy  out  1  high in any state other than IDLE
- timeout_evt  out  1  one-cycle pulse when the watchdog aborts a transfer

Behaviour:
- Reset: state=IDLE; every master output 0; every s_pready/s_prdata/s_pslverr 0; cur_owner=0; round-robin pointer=NCH-1, so channel 0 has first priority; watchdog counter 0; timeout_evt 0.
- Reset asserted mid-transfer aborts immediately. No response is returned to the owner.
- s_penable is deliberately not an input. The block keys only on s_psel, and upstream requesters hold request fields stable until s_pready.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, arb_mode=0: grant channel sel_req if s_psel[sel_req]=1. If sel_req>=NCH, no grant.
- IDLE, arb_mode=1: grant the first channel with s_psel=1, searching from pointer+1 modulo NCH.
- On grant: register the owner's addr/write/prot/wdata/strb onto the master outputs, set PSELx=1, PENABLE=0, cur_owner=grant, go to SETUP. In round-robin mode, pointer=grant.
- SETUP: PENABLE=1, go to ACCESS.
- ACCESS with PREADY=1: PSELx=0, PENABLE=0, capture PRDATA/PSLVERR, go to RESP.
- ACCESS with PREADY=0: stay; increment watchdog.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: PSELx=0, PENABLE=0, captured data=0, error=1, pulse timeout_evt, go to RESP.
- RESP: s_pready[cur_owner]=1 for exactly one cycle, with s_prdata/s_pslverr of that channel driven from the captured values; then IDLE. Watchdog clears.
- Non-owner channels always see pready=0, prdata=0, pslverr=0.
- The owner sees prdata=0 outside RESP.
- Latency with a zero-wait slave: psel sampled in IDLE (cycle 0), SETUP (1), ACCESS (2), s_pready (3). There is a minimum of one IDLE cycle between transfers.
- arb_mode and sel_req are sampled only in IDLE. Changes mid-transfer take effect after RESP.
- s_psel dropping mid-transfer is a protocol violation. The transfer still completes; no assertion is needed in RTL.
- Write data is ignored downstream for reads but is still forwarded as registered.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE/SETUP/ACCESS/RESP), PROT_W=3, watchdog counter width (16).
- One sub-module, apb_rr_arb: combinational rotate-priority search. Inputs: request vector, pointer. Outputs: grant index, valid.
- Flattened-vector slicing lives in the top module.

Test Plan:
- Reset, then NCH=2, arb_mode=0, sel_req=1, ch1 writes 0x1000/0xDEADBEEF with zero-wait slave -> PSELx in cycle 1, PENABLE in cycle 2, s_pready[1] in cycle 3, s_pready[0] stays 0.
- arb_mode=1, NCH=4, channels 0/2/3 requesting continuously -> grant order 0,2,3,0,2,3; each receives exactly one s_pready per transfer.
- Read from ch0 with 3 wait states, PRDATA=0xA5A5A5A5, PSLVERR=1 -> s_prdata[0]=0xA5A5A5A5, s_pslverr[0]=1 in RESP; ch1 outputs stay 0.
- TIMEOUT=8, slave never asserts PREADY -> after 8 ACCESS cycles: timeout_evt pulses, s_pslverr=1, s_prdata=0, PSELx=0; the next transfer proceeds normally.
- sel_req changed from 0 to 1 during ch0's ACCESS -> ch0 completes; ch1 is granted in the IDLE after RESP.
- PRESET asserted during ACCESS -> next cycle all outputs 0, busy=0, no s_pready; the next grant goes to channel 0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the N-channel APB4 master-side arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam int PROT_W = 3;
  localparam int WD_W   = 16;

endpackage

// File: rtl/apb_rr_arb.sv
// Rotating-priority search: first requesting channel after ptr_i, modulo NCH.
module apb_rr_arb #(
  parameter  int NCH  = 2,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_o,
  output logic            valid_o
);

  always_comb begin
    logic [SELW:0] idx;
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NCH; k++) begin
      // ptr_i + k never exceeds 2*NCH-1, so one conditional subtract wraps it
      idx = {1'b0, ptr_i} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(NCH)) idx = idx - (SELW+1)'(NCH);
      if (!valid_o && req_i[idx[SELW-1:0]]) begin
        valid_o = 1'b1;
        gnt_o   = idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB4 master-side arbiter: grants one upstream requester, replays it as a
// registered SETUP/ACCESS pair downstream and returns the response to the owner.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 0,
  localparam int SELW    = $clog2(NCH)
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NCH-1:0]         s_psel,
  input  logic [NCH*AW-1:0]      s_paddr,
  input  logic [NCH-1:0]         s_pwrite,
  input  logic [NCH*PROT_W-1:0]  s_pprot,
  input  logic [NCH*DW-1:0]      s_pwdata,
  input  logic [NCH*(DW/8)-1:0]  s_pstrb,
  output logic [NCH-1:0]         s_pready,
  output logic [NCH*DW-1:0]      s_prdata,
  output logic [NCH-1:0]         s_pslverr,
  output logic                   PSELx,
  output logic [AW-1:0]          PADDR,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [PROT_W-1:0]      PPROT,
  output logic [DW-1:0]          PWDATA,
  output logic [DW/8-1:0]        PSTRB,
  input  logic                   PREADY,
  input  logic [DW-1:0]          PRDATA,
  input  logic                   PSLVERR,
  input  logic                   arb_mode,
  input  logic [SELW-1:0]        sel_req,
  output logic [SELW-1:0]        cur_owner,
  output logic                   busy,
  output logic                   timeout_evt
);

  localparam int              SW       = DW / 8;
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam int              TO_LIM_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WD_W-1:0] TO_LIM   = WD_W'(TO_LIM_I);

  arb_state_e        state_q, state_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [PROT_W-1:0] pprot_q, pprot_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic [SW-1:0]     pstrb_q, pstrb_d;
  logic [SELW-1:0]   owner_q, owner_d, ptr_q, ptr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d, to_evt_q, to_evt_d;

  logic [SELW-1:0]   rr_gnt, gnt;
  logic              rr_valid, fix_valid, gnt_valid;
  logic [AW-1:0]     g_addr;
  logic              g_write;
  logic [PROT_W-1:0] g_prot;
  logic [DW-1:0]     g_wdata;
  logic [SW-1:0]     g_strb;

  apb_rr_arb #(.NCH(NCH)) u_rr (
    .req_i   (s_psel),
    .ptr_i   (ptr_q),
    .gnt_o   (rr_gnt),
    .valid_o (rr_valid)
  );

  // An out-of-range sel_req matches no channel and therefore never grants
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (sel_req == SELW'(i) && s_psel[i]) fix_valid = 1'b1;
  end

  assign gnt       = arb_mode ? rr_gnt : sel_req;
  assign gnt_valid = arb_mode ? rr_valid : fix_valid;

  always_comb begin
    g_addr  = '0;
    g_write = 1'b0;
    g_prot  = '0;
    g_wdata = '0;
    g_strb  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt == SELW'(i)) begin
        g_addr  = s_paddr[i*AW +: AW];
        g_write = s_pwrite[i];
        g_prot  = s_pprot[i*PROT_W +: PROT_W];
        g_wdata = s_pwdata[i*DW +: DW];
        g_strb  = s_pstrb[i*SW +: SW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    to_evt_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          paddr_d   = g_addr;
          pwrite_d  = g_write;
          pprot_d   = g_prot;
          pwdata_d  = g_wdata;
          pstrb_d   = g_strb;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          owner_d   = gnt;
          wd_d      = '0;
          if (arb_mode) ptr_d = gnt;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins over a watchdog expiring in the same cycle
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rdata_d   = PRDATA;
          err_d     = PSLVERR;
          state_d   = RESP;
        end else if (TO_EN && wd_q == TO_LIM) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          to_evt_d  = 1'b1;
          state_d   = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RESP: begin
        wd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= SELW'(NCH - 1);
      wd_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      to_evt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      to_evt_q  <= to_evt_d;
    end
  end

  // Only the owner, and only during RESP, ever sees a non-zero response
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_resp
      logic hit;
      assign hit                   = (state_q == RESP) && (owner_q == SELW'(gi));
      assign s_pready[gi]          = hit;
      assign s_prdata[gi*DW +: DW] = hit ? rdata_q : '0;
      assign s_pslverr[gi]         = hit & err_q;
    end
  endgenerate

  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PPROT       = pprot_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign cur_owner   = owner_q;
  assign busy        = (state_q != IDLE);
  assign timeout_evt = to_evt_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed scenarios then random traffic
// against a transfer-level reference model of arbitration and response routing.
module tb_apb_master_arb;

  localparam int NCH = 4, AW = 32, DW = 32, TIMEOUT = 8, SELW = 2, SW = DW / 8;

  logic                PCLK = 1'b0;
  logic                PRESET;
  logic [NCH-1:0]      s_psel;
  logic [NCH*AW-1:0]   s_paddr;
  logic [NCH-1:0]      s_pwrite;
  logic [NCH*3-1:0]    s_pprot;
  logic [NCH*DW-1:0]   s_pwdata;
  logic [NCH*SW-1:0]   s_pstrb;
  logic [NCH-1:0]      s_pready;
  logic [NCH*DW-1:0]   s_prdata;
  logic [NCH-1:0]      s_pslverr;
  logic                PSELx, PENABLE, PWRITE;
  logic [AW-1:0]       PADDR;
  logic [2:0]          PPROT;
  logic [DW-1:0]       PWDATA;
  logic [SW-1:0]       PSTRB;
  logic                PREADY;
  logic [DW-1:0]       PRDATA;
  logic                PSLVERR;
  logic                arb_mode;
  logic [SELW-1:0]     sel_req;
  logic [SELW-1:0]     cur_owner;
  logic                busy, timeout_evt;

  int total = 0;
  int bad   = 0;

  // Reference model: pending request per channel and the round-robin pointer
  bit          m_psel [NCH];
  logic [AW-1:0] m_addr [NCH];
  bit          m_write[NCH];
  logic [2:0]  m_prot [NCH];
  logic [DW-1:0] m_wdata[NCH];
  logic [SW-1:0] m_strb [NCH];
  int          rr_ptr;

  always #5 PCLK = ~PCLK;

  apb_master_arb #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .s_psel(s_psel), .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_pprot(s_pprot),
    .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .PSELx(PSELx), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .arb_mode(arb_mode), .sel_req(sel_req), .cur_owner(cur_owner), .busy(busy),
    .timeout_evt(timeout_evt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int ch = 0; ch < NCH; ch++) begin
      s_psel[ch]               = m_psel[ch];
      s_paddr[ch*AW +: AW]     = m_addr[ch];
      s_pwrite[ch]             = m_write[ch];
      s_pprot[ch*3 +: 3]       = m_prot[ch];
      s_pwdata[ch*DW +: DW]    = m_wdata[ch];
      s_pstrb[ch*SW +: SW]     = m_strb[ch];
    end
  endtask

  task automatic new_req(input int ch);
    m_psel[ch]  = 1'b1;
    m_addr[ch]  = AW'($urandom);
    m_write[ch] = 1'($urandom);
    m_prot[ch]  = 3'($urandom);
    m_wdata[ch] = DW'($urandom);
    m_strb[ch]  = SW'($urandom);
  endtask

  task automatic model_grant(output int g, output bit v);
    int c;
    v = 1'b0;
    g = 0;
    if (arb_mode == 1'b0) begin
      if (int'(sel_req) < NCH && m_psel[sel_req]) begin
        v = 1'b1;
        g = int'(sel_req);
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        c = (rr_ptr + k) % NCH;
        if (!v && m_psel[c]) begin
          v = 1'b1;
          g = c;
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ctl"}, {PSELx, PENABLE, PWRITE, busy, timeout_evt}, 0);
    chk({pfx, "_paddr"}, PADDR, 0);
    chk({pfx, "_pwdata"}, PWDATA, 0);
    chk({pfx, "_pprot_pstrb"}, {PPROT, PSTRB}, 0);
    chk({pfx, "_owner"}, cur_owner, 0);
    chk({pfx, "_s_pready"}, s_pready, 0);
    chk({pfx, "_s_prdata"}, s_prdata, 0);
    chk({pfx, "_s_pslverr"}, s_pslverr, 0);
  endtask

  // Runs one transfer starting in an IDLE cycle; expected owner comes from the model
  task automatic run_xfer(input int waits, input bit exp_to, input logic [DW-1:0] rd,
                          input bit er, input int new_sel, input bit renew);
    int                own;
    bit                v;
    bit                rdy;
    bit                done;
    int                nacc;
    logic [NCH*DW-1:0] exp_vec;
    logic [NCH-1:0]    onehot;
    logic [DW-1:0]     exp_d;
    bit                exp_e;
    model_grant(own, v);
    chk("idle_busy", busy, 0);
    if (arb_mode) rr_ptr = own;
    @(posedge PCLK); #1;
    chk("setup_sel_en", {PSELx, PENABLE}, 2'b10);
    chk("setup_owner", cur_owner, own);
    chk("setup_paddr", PADDR, m_addr[own]);
    chk("setup_pwrite", PWRITE, m_write[own]);
    chk("setup_pprot", PPROT, m_prot[own]);
    chk("setup_pwdata", PWDATA, m_wdata[own]);
    chk("setup_pstrb", PSTRB, m_strb[own]);
    chk("setup_resp_quiet", {busy, s_pready, s_pslverr}, 9'h100);
    chk("setup_prdata", s_prdata, 0);
    @(posedge PCLK); #1;
    chk("access_sel_en", {PSELx, PENABLE}, 2'b11);
    if (new_sel >= 0) sel_req = SELW'(new_sel);
    done = 1'b0;
    nacc = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      rdy     = !exp_to && (c == waits);
      PREADY  = rdy;
      PRDATA  = rdy ? rd : DW'($urandom);
      PSLVERR = rdy ? er : 1'($urandom);
      @(posedge PCLK); #1;
      PREADY = 1'b0;
      nacc++;
      if (rdy || (exp_to && c == TIMEOUT - 1)) done = 1'b1;
      else chk("access_hold", {PSELx, PENABLE, timeout_evt, s_pready}, 7'b1100000);
    end
    chk("access_bounded", done, 1);
    exp_d   = exp_to ? '0 : rd;
    exp_e   = exp_to ? 1'b1 : er;
    exp_vec = '0;
    exp_vec[own*DW +: DW] = exp_d;
    onehot  = '0;
    onehot[own] = 1'b1;
    chk("resp_pready", s_pready, onehot);
    chk("resp_prdata", s_prdata, exp_vec);
    chk("resp_pslverr", s_pslverr, exp_e ? onehot : '0);
    chk("resp_timeout_evt", timeout_evt, exp_to);
    chk("resp_bus", {PSELx, PENABLE, busy}, 3'b001);
    $display("xfer ch=%0d mode=%0d acc_cycles=%0d timeout=%0d rdata=%h err=%0d",
             own, arb_mode, nacc, exp_to, exp_d, exp_e);
    if (renew) new_req(own);
    else m_psel[own] = 1'b0;
    drive();
    @(posedge PCLK); #1;
    chk("idle_after", {busy, timeout_evt, s_pready, s_pslverr}, 0);
    chk("idle_prdata", s_prdata, 0);
  endtask

  initial begin
    int  g;
    bit  v;
    int  w;
    PRESET   = 1'b1;
    PREADY   = 1'b0;
    PRDATA   = '0;
    PSLVERR  = 1'b0;
    arb_mode = 1'b0;
    sel_req  = '0;
    rr_ptr   = NCH - 1;
    for (int ch = 0; ch < NCH; ch++) begin
      m_psel[ch] = 1'b0; m_addr[ch] = '0; m_write[ch] = 1'b0;
      m_prot[ch] = '0; m_wdata[ch] = '0; m_strb[ch] = '0;
    end
    drive();
    repeat (3) @(posedge PCLK);
    #1;
    chk_all_zero("reset");
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Fixed select of channel 1, write 0x1000 / 0xDEADBEEF, zero-wait slave
    sel_req = 2'd1;
    m_psel[1] = 1'b1; m_addr[1] = 32'h0000_1000; m_write[1] = 1'b1;
    m_prot[1] = 3'd0; m_wdata[1] = 32'hDEAD_BEEF; m_strb[1] = 4'hF;
    drive();
    run_xfer(0, 1'b0, DW'($urandom), 1'b0, -1, 1'b0);

    // Fixed select pointing at an idle channel must not grant
    sel_req = 2'd2;
    new_req(0);
    drive();
    repeat (3) begin
      @(posedge PCLK); #1;
      chk("nogrant", {busy, PSELx}, 0);
    end

    // Round robin with channels 0/2/3 requesting continuously
    arb_mode = 1'b1;
    new_req(2);
    new_req(3);
    drive();
    repeat (6) run_xfer(int'($urandom % 3), 1'b0, DW'($urandom), 1'($urandom), -1, 1'b1);

    // Read from channel 0 with 3 wait states and slave error; channel 1 also pending
    arb_mode = 1'b0;
    sel_req  = 2'd0;
    m_psel[2] = 1'b0;
    m_psel[3] = 1'b0;
    new_req(0);
    m_write[0] = 1'b0;
    new_req(1);
    drive();
    run_xfer(3, 1'b0, 32'hA5A5_A5A5, 1'b1, -1, 1'b0);

    // Watchdog abort, then ready on the last permissible cycle, then a normal transfer
    sel_req = 2'd2;
    new_req(2);
    drive();
    run_xfer(0, 1'b1, DW'($urandom), 1'b0, -1, 1'b1);
    run_xfer(TIMEOUT - 1, 1'b0, DW'($urandom), 1'($urandom), -1, 1'b0);
    sel_req = 2'd1;
    run_xfer(1, 1'b0, DW'($urandom), 1'($urandom), -1, 1'b0);

    // sel_req moved from 0 to 1 during channel 0's ACCESS
    sel_req = 2'd0;
    new_req(0);
    new_req(1);
    drive();
    run_xfer(2, 1'b0, DW'($urandom), 1'($urandom), 1, 1'b1);
    run_xfer(0, 1'b0, DW'($urandom), 1'($urandom), -1, 1'b0);

    // Reset during ACCESS aborts silently and restores channel-0 priority
    for (int ch = 0; ch < NCH; ch++) m_psel[ch] = 1'b0;
    new_req(3);
    arb_mode = 1'b1;
    drive();
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("pre_reset_access", {PSELx, PENABLE, cur_owner}, 4'b1111);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk_all_zero("mid_reset");
    PRESET = 1'b0;
    rr_ptr = NCH - 1;
    new_req(0);
    drive();
    run_xfer(0, 1'b0, DW'($urandom), 1'($urandom), -1, 1'b0);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      for (int ch = 0; ch < NCH; ch++)
        if (!m_psel[ch] && $urandom_range(0, 1) == 1) new_req(ch);
      v = 1'b0;
      for (int ch = 0; ch < NCH; ch++) v = v | m_psel[ch];
      if (!v) new_req(int'($urandom_range(0, NCH - 1)));
      arb_mode = 1'($urandom);
      sel_req  = SELW'($urandom_range(0, NCH - 1));
      drive();
      model_grant(g, v);
      if (!v) begin
        @(posedge PCLK); #1;
        chk("rand_nogrant", {busy, PSELx}, 0);
        arb_mode = 1'b1;
      end
      w = int'($urandom_range(0, 11));
      run_xfer(w, w >= TIMEOUT, DW'($urandom), 1'($urandom), -1, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
